match_round_ctrl: RTL
=====================

MATCH_ROUND_CTRL -- requirements
Module: match_round_ctrl

Interface
REQ-001 SHOW_CYCLES, 25_000_000, mismatch display hold time in clk25MHz cycles (1 s).
REQ-002 MAX_MISS, 7, mismatch count that ends the game as lost.
REQ-003 clk25MHz  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  debounced level button; rising edge starts or restarts a game.
REQ-006 confirm  input  1  debounced level button; rising edge commits the cursor square.
REQ-007 cursor  input  3  square currently highlighted by the active cursor step block (kare0..kare7).
REQ-008 colors  input  24  3-bit color code per square; square n at bits [3n+2:3n].
REQ-009 step_2  output  4  step code broadcast to cursor step blocks: 0000..0111 = pick index; 1000 = done; 1111 = frozen.
REQ-010 picks  output  24  committed square per pick; pick k at bits [3k+2:3k] (feeds secimN/esN of cursor blocks).
REQ-011 pick_valid  output  8  bit k set when pick k is committed.
REQ-012 matched  output  4  bit p set when pair p (picks 2p, 2p+1) matched.
REQ-013 miss_cnt  output  3  mismatches so far, saturating at MAX_MISS.
REQ-014 win / lose  output  1 each  game result flags, mutually exclusive.

Function
REQ-015 FSM states: IDLE, PICK, CHECK, SHOW, DONE.
REQ-016 IDLE: step_2=1111; start edge -> PICK with step_2=0000 and picks, pick_valid, matched, miss_cnt, win, lose all cleared, next cycle.
REQ-017 PICK: confirm edge with pick_valid[cursor square] clear -> write cursor into pick step_2, set its pick_valid bit, next cycle.
REQ-018 PICK: confirm edge on an already-committed square -> ignored, no state change.
REQ-019 After committing an even pick (0,2,4,6): step_2 increments by one, remain PICK.
REQ-020 After committing an odd pick: -> CHECK, step_2=1111.
REQ-021 CHECK (one cycle): colors of picks 2p and 2p+1 equal -> set matched[p]; p=3 -> DONE with win=1, step_2=1000; else PICK with step_2=2p+2.
REQ-022 CHECK unequal -> miss_cnt+1; if new miss_cnt==MAX_MISS -> DONE with lose=1, step_2=1000; else -> SHOW.
REQ-023 SHOW: hold counter runs SHOW_CYCLES cycles, step_2 stays 1111; on expiry clear pick_valid and picks for 2p and 2p+1, -> PICK with step_2=2p.
REQ-024 Edge detection: edge = level high this cycle and low last cycle; a held button produces exactly one edge.
REQ-025 confirm edges in IDLE, CHECK, SHOW, DONE are ignored.
REQ-026 start edge in PICK, CHECK, SHOW is ignored; in DONE it acts as in IDLE (restart).
REQ-027 Same-cycle start and confirm edges: the state's rule for each applies independently; no state accepts both.
REQ-028 Hold counter width 25 bits; counter reloads on each SHOW entry.

Reset
REQ-029 rst asserted: state=IDLE, step_2=1111, picks=0, pick_valid=0, matched=0, miss_cnt=0, win=0, lose=0, hold counter=0, edge-detect history=0, immediately, independent of clock.
REQ-030 rst asserted mid-SHOW or mid-PICK aborts the game; no pending commit survives.
REQ-031 Button held high across rst release produces no edge.

Structure
REQ-032 Shared package holds square constants kare0..kare7, step codes (STEP_DONE=1000, STEP_FROZEN=1111) and the FSM state encoding.
REQ-033 One sub-module rise_det (level in, one-cycle pulse out, async reset), instantiated for start and confirm.

Verification
REQ-034 rst, start edge, confirm on cursor=3 -> next cycle picks[2:0]=3, pick_valid=00000001, step_2=0001.
REQ-035 Pair 0 picks squares 0,5 with equal colors -> CHECK one cycle, matched=0001, step_2=0010.
REQ-036 Pair 0 colors differ (SHOW_CYCLES=4 in bench) -> miss_cnt=1, step_2=1111 for 4 cycles, then step_2=0000, pick_valid=0.
REQ-037 confirm on already-committed square, and confirm held high 10 cycles -> exactly one commit, duplicate ignored.
REQ-038 Four matching pairs -> win=1, step_2=1000; seven mismatches -> lose=1, miss_cnt=7; start edge restarts cleanly.
REQ-039 rst pulsed during SHOW -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/match_round_ctrl_pkg.sv
// Shared constants for the memory-match round controller.
// Square indices, step codes broadcast to the cursor blocks, FSM state encoding.
// Also a helper to pull one square's colour out of the packed colour bus.
package match_round_ctrl_pkg;

  localparam logic [2:0] kare0 = 3'd0;
  localparam logic [2:0] kare1 = 3'd1;
  localparam logic [2:0] kare2 = 3'd2;
  localparam logic [2:0] kare3 = 3'd3;
  localparam logic [2:0] kare4 = 3'd4;
  localparam logic [2:0] kare5 = 3'd5;
  localparam logic [2:0] kare6 = 3'd6;
  localparam logic [2:0] kare7 = 3'd7;

  localparam logic [3:0] STEP_DONE   = 4'b1000;
  localparam logic [3:0] STEP_FROZEN = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    CHECK = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Colour code of square sq; square n lives at bits [3n+2:3n].
  function automatic logic [2:0] square_color(input logic [23:0] colors,
                                              input logic [2:0]  sq);
    return colors[3*sq +: 3];
  endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a debounced level button.
// Pulse is combinational from the level and one register of history.
// The detector stays disarmed for the first clock after reset so a button held through reset never fires.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic hist;
  logic armed;

  // Track last-cycle level and arm after the first clock out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      hist  <= level;
      armed <= 1'b1;
    end
  end

  assign pulse = level & ~hist & armed;

endmodule

// File: rtl/match_round_ctrl.sv
// Round controller for an 8-square memory match game: four pairs of picks.
// Outputs update the cycle after a button edge; CHECK takes one cycle, SHOW holds SHOW_CYCLES.
// Buttons are edge-detected; edges arriving in states that do not use them are dropped.
module match_round_ctrl
  import match_round_ctrl_pkg::*;
#(
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int MAX_MISS    = 7
) (
  input  logic        clk25MHz,
  input  logic        rst,
  input  logic        start,
  input  logic        confirm,
  input  logic [2:0]  cursor,
  input  logic [23:0] colors,
  output logic [3:0]  step_2,
  output logic [23:0] picks,
  output logic [7:0]  pick_valid,
  output logic [3:0]  matched,
  output logic [2:0]  miss_cnt,
  output logic        win,
  output logic        lose
);

  localparam logic [24:0] HOLD_LOAD = 25'(SHOW_CYCLES - 1);
  localparam logic [2:0]  MISS_MAX  = 3'(MAX_MISS);

  state_t      state;
  logic [1:0]  pair;
  logic [24:0] hold;
  logic        start_edge;
  logic        confirm_edge;
  logic        taken;
  logic        colors_eq;
  logic [2:0]  miss_next;
  logic [2:0]  idx;

  rise_det u_start_det (
    .clk   (clk25MHz),
    .rst   (rst),
    .level (start),
    .pulse (start_edge)
  );

  rise_det u_confirm_det (
    .clk   (clk25MHz),
    .rst   (rst),
    .level (confirm),
    .pulse (confirm_edge)
  );

  assign idx       = step_2[2:0];
  assign miss_next = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 3'd1;
  assign colors_eq = square_color(colors, picks[6*pair +: 3]) ==
                     square_color(colors, picks[6*pair + 3 +: 3]);

  // A square is taken when any committed pick already points at it.
  always_comb begin
    taken = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (pick_valid[k] && (picks[3*k +: 3] == cursor)) taken = 1'b1;
    end
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step_2     <= STEP_FROZEN;
      picks      <= '0;
      pick_valid <= '0;
      matched    <= '0;
      miss_cnt   <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      pair       <= '0;
      hold       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state      <= PICK;
            step_2     <= 4'd0;
            picks      <= '0;
            pick_valid <= '0;
            matched    <= '0;
            miss_cnt   <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
          end
        end
        PICK: begin
          if (confirm_edge && !taken) begin
            picks[3*idx +: 3] <= cursor;
            pick_valid[idx]   <= 1'b1;
            if (!idx[0]) begin
              step_2 <= step_2 + 4'd1;
            end else begin
              state  <= CHECK;
              step_2 <= STEP_FROZEN;
              pair   <= idx[2:1];
            end
          end
        end
        CHECK: begin
          if (colors_eq) begin
            matched[pair] <= 1'b1;
            if (pair == 2'd3) begin
              state  <= DONE;
              win    <= 1'b1;
              step_2 <= STEP_DONE;
            end else begin
              state  <= PICK;
              step_2 <= {1'b0, pair + 2'd1, 1'b0};
            end
          end else begin
            miss_cnt <= miss_next;
            if (miss_next == MISS_MAX) begin
              state  <= DONE;
              lose   <= 1'b1;
              step_2 <= STEP_DONE;
            end else begin
              state <= SHOW;
              hold  <= HOLD_LOAD;
            end
          end
        end
        SHOW: begin
          if (hold == '0) begin
            picks[6*pair +: 6]      <= '0;
            pick_valid[2*pair +: 2] <= 2'b00;
            state                   <= PICK;
            step_2                  <= {1'b0, pair, 1'b0};
          end else begin
            hold <= hold - 25'd1;
          end
        end
        default: begin
          state  <= IDLE;
          step_2 <= STEP_FROZEN;
        end
      endcase
    end
  end

endmodule
